// File: rtl/fp_round_pack.sv
// Rounds a sign-magnitude float (3-bit exponent, 4-bit significand) to nearest,
// saturating at the top of range, and queues packed results in a 2-entry FIFO.
module fp_round_pack #(
   parameter int SAT_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [2:0]           in_exp,
   input  logic [3:0]           in_sig,
   input  logic                 in_fifth,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic [2:0]           out_exp,
   output logic [3:0]           out_sig,
   output logic [SAT_CNT_W-1:0] sat_count
);

   // Returns {saturated, sign, exp, sig}; carries ripple from sig into exp and clamp at the top.
   function automatic logic [8:0] round_entry(input logic       sign,
                                              input logic [2:0] exp,
                                              input logic [3:0] sig,
                                              input logic       fifth);
      logic [8:0] r;
      if (!fifth) begin
         r = {1'b0, sign, exp, sig};
      end else if (sig != 4'b1111) begin
         r = {1'b0, sign, exp, sig + 4'd1};
      end else if (exp != 3'd7) begin
         r = {1'b0, sign, exp + 3'd1, 4'b1000};
      end else begin
         r = {1'b1, sign, 3'd7, 4'b1111};
      end
      return r;
   endfunction

   logic [7:0]           mem_q [2];
   logic [7:0]           mem_d [2];
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;
   logic                 in_ready_q, in_ready_d;
   logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;
   logic [8:0]           rounded_s;
   logic                 push_s, pop_s;
   logic [7:0]           head_s;

   always_comb begin
      rounded_s   = round_entry(in_sign, in_exp, in_sig, in_fifth);
      push_s      = in_valid && in_ready_q;
      pop_s       = (count_q != 2'd0) && out_ready;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      sat_count_d = sat_count_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = rounded_s[7:0];
         wr_ptr_d        = ~wr_ptr_q;
         if (rounded_s[8] && (sat_count_q != {SAT_CNT_W{1'b1}})) begin
            sat_count_d = sat_count_q + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
         end else begin
            sat_count_d = sat_count_q;
         end
      end else begin
         mem_d = mem_q;
      end
      if (pop_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};
      // in_ready is registered from the next occupancy, so it never sees out_ready combinationally.
      in_ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0]    <= 8'd0;
         mem_q[1]    <= 8'd0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         in_ready_q  <= 1'b0;
         sat_count_q <= {SAT_CNT_W{1'b0}};
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         sat_count_q <= sat_count_d;
      end
   end

   always_comb begin
      head_s    = mem_q[rd_ptr_q];
      out_valid = (count_q != 2'd0);
      if (out_valid) begin
         {out_sign, out_exp, out_sig} = head_s;
      end else begin
         {out_sign, out_exp, out_sig} = 8'd0;
      end
      in_ready  = in_ready_q;
      sat_count = sat_count_q;
   end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack: rounding cases, saturation counting, backpressure and reset.
module tb_fp_round_pack;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [2:0] in_exp;
   logic [3:0] in_sig;
   logic       in_fifth;
   logic       out_valid;
   logic       out_ready;
   logic       out_sign;
   logic [2:0] out_exp;
   logic [3:0] out_sig;
   logic [7:0] sat_count;
   logic [7:0] out_pk;

   int n_checks = 0;
   int n_errors = 0;

   fp_round_pack #(.SAT_CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_fifth(in_fifth),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
      .sat_count(sat_count)
   );

   assign out_pk = {out_sign, out_exp, out_sig};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [2:0] e,
                        input logic [3:0] g, input logic f);
      in_valid = v;
      in_sign  = s;
      in_exp   = e;
      in_sig   = g;
      in_fifth = f;
   endtask

   // One-sample transfer with out_ready=1: result shows after the edge, then drains.
   task automatic send_check(input string tag, input logic s, input logic [2:0] e,
                             input logic [3:0] g, input logic f, input logic [7:0] exp_pk);
      drive(1'b1, s, e, g, f);
      tick();
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_out"}, out_pk, exp_pk);
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      tick();
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pk", out_pk, 8'h00);
      check("rst_in_ready", in_ready, 0);
      check("rst_sat", sat_count, 8'd0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);

      out_ready = 1'b1;
      send_check("incr", 1'b0, 3'd3, 4'b1011, 1'b1, {1'b0, 3'd3, 4'b1100});
      check("incr_sat", sat_count, 8'd0);
      check("incr_drained", out_valid, 0);
      send_check("carry", 1'b1, 3'd2, 4'b1111, 1'b1, {1'b1, 3'd3, 4'b1000});
      send_check("nofifth", 1'b0, 3'd5, 4'b1010, 1'b0, {1'b0, 3'd5, 4'b1010});
      send_check("fifth_max_sig_no_carry", 1'b0, 3'd7, 4'b1110, 1'b1, {1'b0, 3'd7, 4'b1111});
      check("no_sat_at_1110", sat_count, 8'd0);
      send_check("sat_pos", 1'b0, 3'd7, 4'b1111, 1'b1, {1'b0, 3'd7, 4'b1111});
      check("sat_cnt1", sat_count, 8'd1);
      send_check("sat_neg", 1'b1, 3'd7, 4'b1111, 1'b1, {1'b1, 3'd7, 4'b1111});
      check("sat_cnt2", sat_count, 8'd2);
      send_check("carry_exp6", 1'b0, 3'd6, 4'b1111, 1'b1, {1'b0, 3'd7, 4'b1000});
      check("sat_cnt_still2", sat_count, 8'd2);

      // 300 back-to-back saturating samples; counter must clamp at 255.
      drive(1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
      for (int i = 0; i < 300; i++) begin
         tick();
      end
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      check("sat_stream_in_ready", in_ready, 1);
      check("sat_clamp", sat_count, 8'd255);
      tick();
      tick();
      check("sat_clamp_hold", sat_count, 8'd255);
      check("sat_stream_drained", out_valid, 0);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("rst2_sat", sat_count, 8'd0);
      check("rst2_in_ready", in_ready, 1);

      // Backpressure: A and B fill the FIFO, C waits.
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 3'd1, 4'b0010, 1'b0);
      tick();
      check("bp_a_in_ready", in_ready, 1);
      check("bp_a_head", out_pk, {1'b0, 3'd1, 4'b0010});
      drive(1'b1, 1'b1, 3'd4, 4'b0111, 1'b1);
      tick();
      check("bp_full_in_ready", in_ready, 0);
      check("bp_full_head", out_pk, {1'b0, 3'd1, 4'b0010});
      drive(1'b1, 1'b0, 3'd2, 4'b0100, 1'b1);
      tick();
      check("bp_c_held_in_ready", in_ready, 0);
      check("bp_stable1", out_pk, {1'b0, 3'd1, 4'b0010});
      tick();
      check("bp_stable2", out_pk, {1'b0, 3'd1, 4'b0010});
      check("bp_stable_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      check("bp_b_head", out_pk, {1'b1, 3'd4, 4'b1000});
      check("bp_b_in_ready", in_ready, 1);
      tick();
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      check("bp_c_head", out_pk, {1'b0, 3'd2, 4'b0101});
      check("bp_c_valid", out_valid, 1);
      tick();
      check("bp_drained", out_valid, 0);
      check("bp_drained_pk", out_pk, 8'h00);

      // Concurrent push and pop at occupancy 1.
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 3'd0, 4'b0001, 1'b0);
      tick();
      check("pp_d_head", out_pk, {1'b0, 3'd0, 4'b0001});
      drive(1'b1, 1'b1, 3'd3, 4'b0011, 1'b0);
      out_ready = 1'b1;
      tick();
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      check("pp_e_head", out_pk, {1'b1, 3'd3, 4'b0011});
      check("pp_in_ready", in_ready, 1);
      tick();
      check("pp_drained", out_valid, 0);

      // Reset mid-stream with a full FIFO and sat_count=5.
      drive(1'b1, 1'b1, 3'd7, 4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      tick();
      check("mid_sat5", sat_count, 8'd5);
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 3'd2, 4'b0110, 1'b0);
      tick();
      drive(1'b1, 1'b0, 3'd3, 4'b0101, 1'b1);
      tick();
      check("mid_full_in_ready", in_ready, 0);
      check("mid_full_sat", sat_count, 8'd5);
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 1'b0, 3'd7, 4'b1111, 1'b1);
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_pk", out_pk, 8'h00);
      check("mid_rst_sat", sat_count, 8'd0);
      check("mid_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
      tick();
      check("mid_after_in_ready", in_ready, 1);
      check("mid_after_valid", out_valid, 0);
      check("mid_after_sat", sat_count, 8'd0);
      tick();
      check("mid_after2_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
